// File: rtl/display_scan_if.sv
// Load side and scanned-digit outputs of the seven-segment scanner.
interface display_scan_if #(
    parameter int DIGITS = 8
);
    logic [4*DIGITS-1:0] value_in;
    logic                load;
    logic [DIGITS-1:0]   dp_in;
    logic [3:0]          digit_data;
    logic [DIGITS-1:0]   digit_sel;
    logic                dp_out;
    logic                blank;
    logic                frame_done;

    modport master (
        output value_in, load, dp_in,
        input  digit_data, digit_sel, dp_out, blank, frame_done
    );
    modport slave (
        input  value_in, load, dp_in,
        output digit_data, digit_sel, dp_out, blank, frame_done
    );
endinterface

// File: rtl/display_scan.sv
// Time-multiplexed 7-segment digit scanner with frame-synchronous double buffer
// and leading-zero blanking; feeds a per-digit hex-to-segment decoder.
module display_scan #(
    parameter int DIGITS   = 8,
    parameter int PRESCALE = 50000,
    parameter bit LZ_BLANK = 1'b1
) (
    input logic           clk,
    input logic           rst,
    display_scan_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = 4 * DIGITS;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]     prescaler_q, prescaler_d;
    logic [IW-1:0]     index_q, index_d;
    logic [VW-1:0]     shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [VW-1:0]     pend_val_q, pend_val_d;
    logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic              pend_valid_q, pend_valid_d;
    logic [3:0]        digit_data_q, digit_data_d;
    logic [DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic              dp_out_q, dp_out_d;
    logic              blank_q, blank_d;
    logic              frame_done_q, frame_done_d;

    logic              tick_s, boundary_s;
    logic              zacc_s;
    logic [DIGITS-1:0] zero_from_s;
    logic [3:0]        nib_s;
    logic              dp_s;

    // Prescaler, digit index and the pending/shadow double buffer.
    always_comb begin
        tick_s       = (prescaler_q == PRE_LAST);
        boundary_s   = tick_s && (index_q == IDX_LAST);
        prescaler_d  = tick_s ? '0 : prescaler_q + PW'(1);
        if (boundary_s) begin
            index_d = '0;
        end else if (tick_s) begin
            index_d = index_q + IW'(1);
        end else begin
            index_d = index_q;
        end

        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        if (boundary_s) begin
            // A load landing on the wrap bypasses and discards any older pending value.
            if (bus.load) begin
                shadow_val_d = bus.value_in;
                shadow_dp_d  = bus.dp_in;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                shadow_val_d = pend_val_q;
                shadow_dp_d  = pend_dp_q;
                pend_valid_d = 1'b0;
            end else begin
                pend_valid_d = 1'b0;
            end
        end else if (bus.load) begin
            pend_val_d   = bus.value_in;
            pend_dp_d    = bus.dp_in;
            pend_valid_d = 1'b1;
        end else begin
            pend_valid_d = pend_valid_q;
        end
    end

    // Next-cycle digit outputs, taken from the shadow as it will stand after this edge.
    always_comb begin
        zacc_s = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zacc_s         = zacc_s && (shadow_val_d[4*k +: 4] == 4'h0) && !shadow_dp_d[k];
            zero_from_s[k] = zacc_s;
        end
        nib_s = 4'h0;
        dp_s  = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (index_d == IW'(k)) begin
                nib_s = shadow_val_d[4*k +: 4];
                dp_s  = shadow_dp_d[k];
            end else begin
                nib_s = nib_s;
                dp_s  = dp_s;
            end
        end
        blank_d      = LZ_BLANK && (index_d != '0) && zero_from_s[index_d];
        digit_data_d = blank_d ? 4'h0 : nib_s;
        dp_out_d     = blank_d ? 1'b0 : dp_s;
        for (int k = 0; k < DIGITS; k++) begin
            digit_sel_d[k] = blank_d || (index_d != IW'(k));
        end
        frame_done_d = boundary_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_q  <= '0;
            index_q      <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            digit_data_q <= 4'h0;
            digit_sel_q  <= {{(DIGITS-1){1'b1}}, 1'b0};
            dp_out_q     <= 1'b0;
            blank_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            prescaler_q  <= prescaler_d;
            index_q      <= index_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            digit_data_q <= digit_data_d;
            digit_sel_q  <= digit_sel_d;
            dp_out_q     <= dp_out_d;
            blank_q      <= blank_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.digit_data = digit_data_q;
    assign bus.digit_sel  = digit_sel_q;
    assign bus.dp_out     = dp_out_q;
    assign bus.blank      = blank_q;
    assign bus.frame_done = frame_done_q;
endmodule
